fir_stream_feeder: RTL

Upstream sample source for the 8-bit pipelined FIR datapath. Accepts samples from a producer over a valid/ready handshake, buffers them in a small FIFO, and drives the filter's free-running one-sample-per-clock input, emitting zeros when starved. It also runs a matching delay line so downstream logic knows which filter outputs correspond to real input samples.

---
 rtl/fir_stream_feeder.sv | 133 +++++++++++++
 1 files changed

// File: rtl/fir_stream_feeder.sv
// fir_stream_feeder: buffers producer samples in a small FIFO and drives the
// FIR filter's free-running one-sample-per-clock input, inserting zeros when
// starved, plus a delay line that marks which filter outputs are real.
module fir_stream_feeder #(
  parameter int WORD_SIZE_IN = 8,
  parameter int DEPTH        = 8,
  parameter int LATENCY      = 17
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       enable,
  input  logic [WORD_SIZE_IN-1:0]    s_data,
  input  logic                       s_valid,
  output logic                       s_ready,
  output logic [WORD_SIZE_IN-1:0]    sample_out,
  output logic                       sample_valid,
  output logic                       out_valid,
  output logic                       underrun,
  input  logic                       clear_underrun,
  output logic [$clog2(DEPTH):0]     fill_level
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] FILL = 2'd1;
  localparam logic [1:0] RUN  = 2'd2;

  logic [1:0]              state;
  logic [1:0]              state_next;
  logic [WORD_SIZE_IN-1:0] mem [DEPTH];
  logic [AW-1:0]           wr_ptr;
  logic [AW-1:0]           rd_ptr;
  logic [CW-1:0]           count;
  logic [LATENCY-1:0]      valid_pipe;
  logic                    push;
  logic                    pop;
  logic                    fifo_empty;
  logic                    underrun_event;

  // The pop decision looks only at the pre-push occupancy, so a sample
  // pushed into an empty FIFO is never bypassed straight to the filter.
  assign fifo_empty     = (count == '0);
  assign s_ready        = (count < CW'(DEPTH));
  assign push           = s_valid && s_ready;
  assign pop            = (state == RUN) && enable && !fifo_empty;
  assign underrun_event = (state == RUN) && fifo_empty;
  assign fill_level     = count;
  assign out_valid      = valid_pipe[LATENCY-1];

  // Next-state logic; dropping enable always returns to IDLE first.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (enable) state_next = FILL;
      FILL: begin
        if (!enable)
          state_next = IDLE;
        else if (count >= CW'(DEPTH / 2))
          state_next = RUN;
      end
      RUN:  if (!enable) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)
      state <= IDLE;
    else
      state <= state_next;
  end

  // FIFO storage; contents deliberately survive reset.
  always_ff @(posedge clock) begin
    if (push)
      mem[wr_ptr] <= s_data;
  end

  // FIFO pointers and occupancy counter.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + AW'(1);
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Registered filter input: a real sample on a pop, zero fill otherwise.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sample_out   <= '0;
      sample_valid <= 1'b0;
    end else if (pop) begin
      sample_out   <= mem[rd_ptr];
      sample_valid <= 1'b1;
    end else begin
      sample_out   <= '0;
      sample_valid <= 1'b0;
    end
  end

  // Sticky underrun flag; a fresh underrun beats a same-cycle clear.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)
      underrun <= 1'b0;
    else if (underrun_event)
      underrun <= 1'b1;
    else if (clear_underrun)
      underrun <= 1'b0;
  end

  // Delay line tracking sample_valid through the filter's latency.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)
      valid_pipe <= '0;
    else
      valid_pipe <= {valid_pipe[LATENCY-2:0], sample_valid};
  end

endmodule
